// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues one per cycle, collects results in order
module alu_issue_queue #(
  parameter int CDEPTH = 4,
  parameter int RDEPTH = 8,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [15:0]     cmd_a,
  input  logic [15:0]     cmd_b,
  input  logic [1:0]      cmd_op,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [1:0]      alu_op,
  input  logic [31:0]     alu_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);
  localparam int CAW = $clog2(CDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CW = 34 + TAGW;
  localparam int RW = 32 + TAGW;
  localparam logic [RAW+1:0] RLIM = (RAW+2)'(RDEPTH);
  logic [CW-1:0]   cmem [CDEPTH];
  logic [RW-1:0]   rmem [RDEPTH];
  logic [CAW:0]    cwp, crp;
  logic [RAW:0]    rwp, rrp, r_count;
  logic            cmd_empty, cmd_full, r_empty, r_full, push, issue, r_pop;
  logic            t0_v, t1_v, t2_v;
  logic [TAGW-1:0] t0_tag, t1_tag, t2_tag;
  logic [1:0]      inflight;
  logic [RAW+1:0]  occ;
  logic [CW-1:0]   head;
  // Occupancy, credit check and handshakes; the credit counts every result that could still land
  always_comb begin
    cmd_empty = cwp == crp;
    cmd_full = (cwp[CAW] != crp[CAW]) && (cwp[CAW-1:0] == crp[CAW-1:0]);
    r_count = rwp - rrp;
    r_empty = r_count == '0;
    r_full = r_count[RAW];
    inflight = {1'b0, t0_v} + {1'b0, t1_v} + {1'b0, t2_v};
    occ = {1'b0, r_count} + {{RAW{1'b0}}, inflight};
    issue = !cmd_empty && occ < RLIM;
    head = cmem[crp[CAW-1:0]];
    push = cmd_valid && !cmd_full;
    r_pop = !r_empty && res_ready;
  end
  assign cmd_ready = !cmd_full;
  assign res_valid = !r_empty;
  assign {res_tag, res_data} = rmem[rrp[RAW-1:0]];
  assign busy = !cmd_empty || t0_v || t1_v || t2_v || !r_empty;
  // FIFO storage; stale contents are harmless because pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) cmem[cwp[CAW-1:0]] <= {cmd_tag, cmd_op, cmd_a, cmd_b};
    if (t2_v) rmem[rwp[RAW-1:0]] <= {t2_tag, alu_y};
  end
  // Pointers, operand registers and the tag pipeline that shadows the ALU latency
  always_ff @(posedge clk) begin
    if (reset) begin
      cwp <= '0;
      crp <= '0;
      rwp <= '0;
      rrp <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      t0_v <= 1'b0;
      t1_v <= 1'b0;
      t2_v <= 1'b0;
      t0_tag <= '0;
      t1_tag <= '0;
      t2_tag <= '0;
    end else begin
      if (push) cwp <= cwp + (CAW+1)'(1);
      if (issue) begin
        crp <= crp + (CAW+1)'(1);
        alu_b <= head[15:0];
        alu_a <= head[31:16];
        alu_op <= head[33:32];
        t0_tag <= head[CW-1:34];
      end
      t0_v <= issue;
      t1_v <= t0_v;
      t2_v <= t1_v;
      t1_tag <= t0_tag;
      t2_tag <= t1_tag;
      if (t2_v) rwp <= rwp + (RAW+1)'(1);
      if (r_pop) rrp <= rrp + (RAW+1)'(1);
    end
  end
endmodule
